// File: rtl/layer_injector_pkg.sv
// ============================================================================
// Module : layer_injector_pkg
// Brief  : NoC flit geometry shared by the layer injector and layer endpoint.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package layer_injector_pkg;

    localparam int FLIT_DATA_WIDTH     = 16;
    localparam int NUM_USER_RECV_PORTS = 4;
    localparam int FLIT_BUFFER_DEPTH   = 4;

    localparam int DEST_BITS       = $clog2(NUM_USER_RECV_PORTS);
    localparam int PAYLOAD_BITS    = FLIT_DATA_WIDTH - 1;
    localparam int FLIT_PORT_WIDTH = 2 + FLIT_DATA_WIDTH + DEST_BITS + 2;

    // The data field is {marker, payload}; the marker takes the top data bit.
    localparam int VALID_BIT   = FLIT_PORT_WIDTH - 1;
    localparam int TAIL_BIT    = FLIT_PORT_WIDTH - 2;
    localparam int DEST_MSB    = FLIT_PORT_WIDTH - 3;
    localparam int DEST_LSB    = FLIT_PORT_WIDTH - 2 - DEST_BITS;
    localparam int VC_MSB      = DEST_LSB - 1;
    localparam int VC_LSB      = DEST_LSB - 2;
    localparam int MARKER_BIT  = FLIT_DATA_WIDTH - 1;
    localparam int PAYLOAD_MSB = FLIT_DATA_WIDTH - 2;
    localparam int PAYLOAD_LSB = 0;

    typedef logic [DEST_BITS-1:0]       dest_t;
    typedef logic [PAYLOAD_BITS-1:0]    payload_t;
    typedef logic [FLIT_PORT_WIDTH-1:0] flit_t;

    typedef struct packed {
        dest_t    dest;
        payload_t payload;
    } fifo_word_t;

    function automatic flit_t build_flit(input dest_t dest, input payload_t payload);
        return {1'b1, 1'b1, dest, 2'b00, 1'b1, payload};
    endfunction

endpackage

`default_nettype wire

// File: rtl/layer_injector_if.sv
// ============================================================================
// Module : layer_injector_if
// Brief  : Producer-side valid/ready word channel into the layer injector.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface layer_injector_if;
    import layer_injector_pkg::*;

    logic     in_valid;
    logic     in_ready;
    payload_t in_data;
    dest_t    in_dest;

    modport master (output in_valid, output in_data, output in_dest, input in_ready);
    modport slave  (input in_valid, input in_data, input in_dest, output in_ready);

endinterface

`default_nettype wire

// File: rtl/layer_fifo.sv
// ============================================================================
// Module : layer_fifo
// Brief  : Parameterised synchronous FIFO with occupancy count.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module layer_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  wire logic                   clk,
    input  wire logic                   rst_n,
    input  wire logic                   push_i,
    input  wire logic                   pop_i,
    input  wire logic [WIDTH-1:0]       wdata_i,
    output logic      [WIDTH-1:0]       rdata_o,
    output logic                        full_o,
    output logic                        empty_o,
    output logic      [$clog2(DEPTH):0] count_o
);

    localparam int             PTR_W   = $clog2(DEPTH);
    localparam logic [PTR_W:0] DEPTH_C = (PTR_W + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W:0]   count_q;
    logic [PTR_W:0]   count_d;
    logic             w_push;
    logic             w_pop;

    assign full_o  = (count_q == DEPTH_C);
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];
    assign w_push  = push_i && !full_o;
    assign w_pop   = pop_i && !empty_o;

    always_comb begin
        count_d = count_q;
        if (w_push && !w_pop) begin
            count_d = count_q + 1'b1;
        end else if (!w_push && w_pop) begin
            count_d = count_q - 1'b1;
        end
    end

    // Power-of-two depth lets the pointers wrap naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            count_q <= count_d;
            if (w_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (w_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

`default_nettype wire

// File: rtl/layer_injector.sv
// ============================================================================
// Module : layer_injector
// Brief  : Buffers producer words and injects credit-gated single-flit packets.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module layer_injector
    import layer_injector_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int CREDITS    = FLIT_BUFFER_DEPTH
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    layer_injector_if.slave   prod,
    output logic              send_flit_o,
    output flit_t             flit_out_o,
    input  wire logic         credit_in_i,
    output logic [15:0]       sent_count_o,
    output logic              credit_err_o
);

    localparam int              CNT_W        = $clog2(FIFO_DEPTH) + 1;
    localparam int              CRED_W       = $clog2(CREDITS + 1);
    localparam logic [CNT_W-1:0]  FIFO_DEPTH_C = CNT_W'(FIFO_DEPTH);
    localparam logic [CRED_W-1:0] CREDITS_C    = CRED_W'(CREDITS);

    fifo_word_t        w_wdata;
    fifo_word_t        w_head;
    logic              w_full;
    logic              w_empty;
    logic [CNT_W-1:0]  w_count;
    logic              w_push;
    logic              w_inject;

    logic [CRED_W-1:0] credits_q, credits_d;
    logic              send_q, send_d;
    flit_t             flit_q, flit_d;
    logic [15:0]       sent_q, sent_d;
    logic              err_q, err_d;

    assign prod.in_ready = (w_count != FIFO_DEPTH_C);
    assign w_push        = prod.in_valid && !w_full;
    assign w_wdata       = '{dest: prod.in_dest, payload: prod.in_data};
    assign w_inject      = !w_empty && (credits_q != '0);

    layer_fifo #(
        .WIDTH ($bits(fifo_word_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (w_push),
        .pop_i   (w_inject),
        .wdata_i (w_wdata),
        .rdata_o (w_head),
        .full_o  (w_full),
        .empty_o (w_empty),
        .count_o (w_count)
    );

    always_comb begin
        credits_d = credits_q;
        err_d     = err_q;
        send_d    = w_inject;
        sent_d    = sent_q;
        flit_d    = {1'b0, flit_q[FLIT_PORT_WIDTH-2:0]};
        // A simultaneous return and injection cancel out.
        if (credit_in_i && !w_inject) begin
            if (credits_q == CREDITS_C) begin
                err_d = 1'b1;
            end else begin
                credits_d = credits_q + 1'b1;
            end
        end else if (!credit_in_i && w_inject) begin
            credits_d = credits_q - 1'b1;
        end
        if (w_inject) begin
            flit_d = build_flit(w_head.dest, w_head.payload);
            sent_d = sent_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            credits_q <= CREDITS_C;
            send_q    <= 1'b0;
            flit_q    <= '0;
            sent_q    <= '0;
            err_q     <= 1'b0;
        end else begin
            credits_q <= credits_d;
            send_q    <= send_d;
            flit_q    <= flit_d;
            sent_q    <= sent_d;
            err_q     <= err_d;
        end
    end

    assign send_flit_o  = send_q;
    assign flit_out_o   = flit_q;
    assign sent_count_o = sent_q;
    assign credit_err_o = err_q;

endmodule

`default_nettype wire
